// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the register-file write port among NREQ write-back requesters, one grant per cycle.
// Define WB_FIXED_PRIO_EN to replace round-robin with fixed lowest-index-wins priority.
module regfile_wb_arbiter #(
    parameter int NREQ = 4,
    parameter int AW   = 5,
    parameter int DW   = 32
) (
    input  logic               Clk,
    input  logic               Rst_n,
    input  logic [NREQ-1:0]    Req,
    input  logic [NREQ*AW-1:0] Req_Addr,
    input  logic [NREQ*DW-1:0] Req_Data,
    input  logic               Hold,
    output logic [NREQ-1:0]    Ack,
    output logic               Wr_En,
    output logic [AW-1:0]      Wr_Addr,
    output logic [DW-1:0]      Wr_Data,
    output logic               Busy
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    typedef enum logic [1:0] {IDLE, ISSUE, STALL} state_t;
    state_t state, state_nxt;
    logic [NREQ-1:0] req_m, gnt_q, oh;
    logic [PW-1:0] win, win_lo;
    logic [AW-1:0] addr_sel;
    logic [DW-1:0] data_sel;
    logic found, gnt;
    // The request being acked this cycle is already issued, so it must not win again.
    assign req_m = Req & ~Ack;
    assign found = |req_m;
    assign gnt   = found && !Hold;
    assign Ack   = (state == ISSUE) ? gnt_q : '0;
    assign Wr_En = (state == ISSUE) && (Wr_Addr != '0);
    assign Busy  = Rst_n && found;
    always_comb begin
        win_lo = '0;
        for (int i = NREQ - 1; i >= 0; i--)
            win_lo = req_m[i] ? PW'(i) : win_lo;
    end
`ifdef WB_FIXED_PRIO_EN
    assign win = win_lo;
`else
    logic [PW-1:0] ptr, win_hi;
    logic hi;
    // Prefer the lowest requester at or above ptr; otherwise wrap to the lowest overall.
    always_comb begin
        hi = 1'b0;
        win_hi = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_m[i] && PW'(i) >= ptr) begin
                hi = 1'b1;
                win_hi = PW'(i);
            end
        end
    end
    assign win = hi ? win_hi : win_lo;
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n)
            ptr <= '0;
        else if (gnt)
            ptr <= (win == PW'(NREQ - 1)) ? '0 : win + 1'b1;
    end
`endif
    always_comb begin
        oh = '0;
        addr_sel = '0;
        data_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (PW'(i) == win) begin
                oh[i] = 1'b1;
                addr_sel = Req_Addr[i*AW +: AW];
                data_sel = Req_Data[i*DW +: DW];
            end
        end
        state_nxt = Hold ? STALL : (found ? ISSUE : IDLE);
    end
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state   <= IDLE;
            gnt_q   <= '0;
            Wr_Addr <= '0;
            Wr_Data <= '0;
        end else begin
            state <= state_nxt;
            if (gnt) begin
                gnt_q   <= oh;
                Wr_Addr <= addr_sel;
                Wr_Data <= data_sel;
            end
        end
    end
endmodule
